// File: rtl/skin_segm_cfg_ctrl.sv
// Frame-synchronous configuration controller for the skin-colour segmentation path.
// Host writes land in shadow registers; a commit is applied atomically at the next vsync rise.
module skin_segm_cfg_ctrl #(
    parameter int unsigned FRAME_CNT_W = 16,
    parameter logic [7:0]  CB_MIN_RST  = 8'd77,
    parameter logic [7:0]  CB_MAX_RST  = 8'd127,
    parameter logic [7:0]  CR_MIN_RST  = 8'd133,
    parameter logic [7:0]  CR_MAX_RST  = 8'd173
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [7:0]             cfg_wdata,
    input  logic                   cfg_commit,
    input  logic                   in_vsync,
    output logic                   cfg_busy,
    output logic                   cfg_applied,
    output logic                   cfg_err,
    output logic                   conv_ce,
    output logic [7:0]             cb_min,
    output logic [7:0]             cb_max,
    output logic [7:0]             cr_min,
    output logic [7:0]             cr_max,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {StIdle, StPending, StApply} state_e;

    localparam logic [FRAME_CNT_W-1:0] FrameOne = FRAME_CNT_W'(1);

    state_e state_q, state_d;

    logic                   vsync_q;
    logic                   vsync_rise;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   applied_q;
    logic                   err_q;

    logic [7:0] sh_cb_min_q, sh_cb_max_q, sh_cr_min_q, sh_cr_max_q;
    logic       sh_en_q;
    logic [7:0] act_cb_min_q, act_cb_max_q, act_cr_min_q, act_cr_max_q;
    logic       act_en_q;

    logic shadow_valid;

    assign vsync_rise   = in_vsync & ~vsync_q;
    assign shadow_valid = (sh_cb_min_q <= sh_cb_max_q) && (sh_cr_min_q <= sh_cr_max_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cfg_commit) state_d = StPending;
            StPending: if (vsync_rise) state_d = StApply;
            StApply:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vsync_q     <= 1'b0;
            frame_cnt_q <= '0;
            applied_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            vsync_q   <= in_vsync;
            applied_q <= (state_q == StApply) && shadow_valid;
            err_q     <= (state_q == StApply) && !shadow_valid;
            if (vsync_rise) frame_cnt_q <= frame_cnt_q + FrameOne;
        end
    end

    // Shadow is only writable while idle, so a pending commit sees a frozen set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_cb_min_q <= CB_MIN_RST;
            sh_cb_max_q <= CB_MAX_RST;
            sh_cr_min_q <= CR_MIN_RST;
            sh_cr_max_q <= CR_MAX_RST;
            sh_en_q     <= 1'b1;
        end else if (state_q == StIdle && cfg_we) begin
            case (cfg_addr)
                3'd0:    sh_cb_min_q <= cfg_wdata;
                3'd1:    sh_cb_max_q <= cfg_wdata;
                3'd2:    sh_cr_min_q <= cfg_wdata;
                3'd3:    sh_cr_max_q <= cfg_wdata;
                3'd4:    sh_en_q     <= cfg_wdata[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cb_min_q <= CB_MIN_RST;
            act_cb_max_q <= CB_MAX_RST;
            act_cr_min_q <= CR_MIN_RST;
            act_cr_max_q <= CR_MAX_RST;
            act_en_q     <= 1'b1;
        end else if (state_q == StApply && shadow_valid) begin
            act_cb_min_q <= sh_cb_min_q;
            act_cb_max_q <= sh_cb_max_q;
            act_cr_min_q <= sh_cr_min_q;
            act_cr_max_q <= sh_cr_max_q;
            act_en_q     <= sh_en_q;
        end
    end

    assign cfg_busy    = (state_q != StIdle);
    assign cfg_applied = applied_q;
    assign cfg_err     = err_q;
    assign conv_ce     = act_en_q;
    assign cb_min      = act_cb_min_q;
    assign cb_max      = act_cb_max_q;
    assign cr_min      = act_cr_min_q;
    assign cr_max      = act_cr_max_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_skin_segm_cfg_ctrl.sv
// Bench for skin_segm_cfg_ctrl: directed scenarios plus random traffic against a
// commit/apply reference model; a second instance with a 4-bit frame counter checks wrap.
module tb_skin_segm_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       cfg_commit = 1'b0;
    logic       in_vsync = 1'b0;

    logic        cfg_busy, cfg_applied, cfg_err, conv_ce;
    logic [7:0]  cb_min, cb_max, cr_min, cr_max;
    logic [15:0] frame_cnt;

    logic        b4, a4, e4, ce4;
    logic [7:0]  cbl4, cbh4, crl4, crh4;
    logic [3:0]  fc4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    skin_segm_cfg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .in_vsync(in_vsync),
        .cfg_busy(cfg_busy), .cfg_applied(cfg_applied), .cfg_err(cfg_err),
        .conv_ce(conv_ce), .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min),
        .cr_max(cr_max), .frame_cnt(frame_cnt)
    );

    skin_segm_cfg_ctrl #(.FRAME_CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .in_vsync(in_vsync),
        .cfg_busy(b4), .cfg_applied(a4), .cfg_err(e4),
        .conv_ce(ce4), .cb_min(cbl4), .cb_max(cbh4), .cr_min(crl4),
        .cr_max(crh4), .frame_cnt(fc4)
    );

    // Reference model: index 0-3 thresholds, 4 enable bit.
    int  m_shadow [5];
    int  m_active [5];
    bit  m_pending, m_apply, m_applied, m_err, m_vs_prev;
    int  m_frames;

    function automatic void model_reset();
        m_shadow = '{77, 127, 133, 173, 1};
        m_active = '{77, 127, 133, 173, 1};
        m_pending = 0; m_apply = 0; m_applied = 0; m_err = 0; m_vs_prev = 0;
        m_frames = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit rise;
            rise = in_vsync && !m_vs_prev;
            m_applied = 0;
            m_err = 0;
            if (m_apply) begin
                m_apply = 0;
                if (m_shadow[0] <= m_shadow[1] && m_shadow[2] <= m_shadow[3]) begin
                    m_active = m_shadow;
                    m_applied = 1;
                end else begin
                    m_err = 1;
                end
            end else if (m_pending) begin
                if (rise) begin
                    m_pending = 0;
                    m_apply = 1;
                end
            end else begin
                if (cfg_we && cfg_addr < 3'd5)
                    m_shadow[cfg_addr] = (cfg_addr == 3'd4) ? int'(cfg_wdata[0]) : int'(cfg_wdata);
                if (cfg_commit) m_pending = 1;
            end
            if (rise) m_frames++;
            m_vs_prev = in_vsync;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy",      int'(cfg_busy),    int'(m_pending || m_apply));
            chk("applied",   int'(cfg_applied), int'(m_applied));
            chk("err",       int'(cfg_err),     int'(m_err));
            chk("conv_ce",   int'(conv_ce),     m_active[4]);
            chk("cb_min",    int'(cb_min),      m_active[0]);
            chk("cb_max",    int'(cb_max),      m_active[1]);
            chk("cr_min",    int'(cr_min),      m_active[2]);
            chk("cr_max",    int'(cr_max),      m_active[3]);
            chk("frame_cnt", int'(frame_cnt),   m_frames % 65536);
            chk("w4_frame",  int'(fc4),         m_frames % 16);
            chk("w4_state",  int'({b4, a4, e4, ce4}),
                int'({cfg_busy, cfg_applied, cfg_err, conv_ce}));
            chk("w4_thr",    int'({cbl4, cbh4, crl4, crh4}),
                int'({cb_min, cb_max, cr_min, cr_max}));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        cyc(1);
        cfg_commit = 1'b0;
    endtask

    task automatic vsync_pulse();
        in_vsync = 1'b1; cyc(3);
        in_vsync = 1'b0; cyc(3);
    endtask

    task automatic do_reset();
        cyc(1);
        rst_n = 1'b0;
        #2;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        do_reset();
        chk("rst_cb_min", int'(cb_min), 77);
        chk("rst_cb_max", int'(cb_max), 127);
        chk("rst_cr_min", int'(cr_min), 133);
        chk("rst_cr_max", int'(cr_max), 173);
        chk("rst_ce",     int'(conv_ce), 1);
        chk("rst_busy",   int'(cfg_busy), 0);
        chk("rst_frame",  int'(frame_cnt), 0);

        // Basic commit and apply latency.
        wr(3'd0, 8'd90);
        wr(3'd3, 8'd160);
        commit();
        cyc(2);
        chk("pend_busy", int'(cfg_busy), 1);
        chk("pend_cb_min_old", int'(cb_min), 77);
        in_vsync = 1'b1;
        cyc(1);
        chk("edge1_applied", int'(cfg_applied), 0);
        chk("edge1_cb_min", int'(cb_min), 77);
        chk("edge1_busy", int'(cfg_busy), 1);
        cyc(1);
        chk("edge2_applied", int'(cfg_applied), 1);
        chk("edge2_cb_min", int'(cb_min), 90);
        chk("edge2_cr_max", int'(cr_max), 160);
        chk("edge2_busy", int'(cfg_busy), 0);
        in_vsync = 1'b0;
        cyc(3);

        // Invalid commit, then correction.
        wr(3'd0, 8'd200);
        wr(3'd1, 8'd100);
        commit();
        vsync_pulse();
        chk("bad_cb_min_kept", int'(cb_min), 90);
        chk("bad_cb_max_kept", int'(cb_max), 127);
        wr(3'd1, 8'd220);
        commit();
        vsync_pulse();
        chk("fix_cb_min", int'(cb_min), 200);
        chk("fix_cb_max", int'(cb_max), 220);

        // Writes and commit while pending are ignored; ignored addresses too.
        wr(3'd2, 8'd140);
        commit();
        wr(3'd1, 8'd10);
        commit();
        wr(3'd5, 8'd0);
        vsync_pulse();
        chk("frozen_cb_max", int'(cb_max), 220);
        chk("frozen_cr_min", int'(cr_min), 140);
        chk("frozen_busy", int'(cfg_busy), 0);

        // Same-cycle write+commit carries the enable=0 write.
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 8'h00; cfg_commit = 1'b1;
        cyc(1);
        cfg_we = 1'b0; cfg_commit = 1'b0;
        in_vsync = 1'b1;
        cyc(1);
        chk("ce_before", int'(conv_ce), 1);
        cyc(1);
        chk("ce_at_applied", int'({cfg_applied, conv_ce}), 2);
        in_vsync = 1'b0;
        cyc(3);

        // Reset while pending drops the commit.
        wr(3'd0, 8'd50);
        commit();
        cyc(1);
        rst_n = 1'b0;
        #2;
        chk("rst_mid_busy", int'(cfg_busy), 0);
        chk("rst_mid_ce", int'(conv_ce), 1);
        cyc(1);
        rst_n = 1'b1;
        vsync_pulse();
        chk("rst_mid_cb_min", int'(cb_min), 77);
        chk("rst_mid_busy2", int'(cfg_busy), 0);

        // Frame counter wrap on the 4-bit instance.
        do_reset();
        repeat (17) vsync_pulse();
        chk("wrap4", int'(fc4), 1);
        chk("count17", int'(frame_cnt), 17);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            int r;
            cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_addr   = 3'($urandom_range(0, 7));
            r          = $urandom_range(0, 3);
            cfg_wdata  = (r == 0) ? 8'($urandom_range(0, 40)) :
                         (r == 1) ? 8'($urandom_range(200, 255)) : 8'($urandom);
            cfg_commit = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) in_vsync = ~in_vsync;
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            cyc(1);
        end
        cfg_we = 1'b0; cfg_commit = 1'b0; in_vsync = 1'b0;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
